pwm_duty_ramp_ctrl: RTL and testbench



---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_period_prescaler.sv | 36 +++
 rtl/pwm_duty_ramp_ctrl.sv | 92 +++++++++
 tb/tb_pwm_duty_ramp_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and saturating helpers for the PWM duty ramp controller.
package pwm_pkg;

  localparam int unsigned DEF_DUTY_W   = 4;
  localparam int unsigned DEF_DUTY_MAX = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

  // Clamp an absolute duty request to the legal maximum.
  function automatic int unsigned clamp_max(input int unsigned v, input int unsigned max_v);
    return (v > max_v) ? max_v : v;
  endfunction

  // One saturating step up or down within [0, max_v].
  function automatic int unsigned sat_adjust(input int unsigned v, input logic up,
                                             input int unsigned max_v);
    if (up) return (v >= max_v) ? max_v : v + 1;
    return (v == 0) ? 0 : v - 1;
  endfunction

endpackage

// File: rtl/pwm_period_prescaler.sv
// Counts PWM period strobes and emits a combinational step tick every RAMP_DIV strobes.
module pwm_period_prescaler #(
  parameter int unsigned RAMP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic period_start_i,
  output logic step_tick_c
);

  localparam int unsigned CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned LAST  = RAMP_DIV - 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             terminal;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d       = cnt_q;
    terminal    = (cnt_q == CNT_W'(LAST));
    step_tick_c = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (period_start_i) begin
      step_tick_c = terminal;
      cnt_d       = terminal ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Sequences the PWM compare duty: accepts targets and +/-1 requests, then ramps the applied
// duty one step per RAMP_DIV PWM periods, changing it only right after a period boundary.
module pwm_duty_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY_W    = DEF_DUTY_W,
  parameter int unsigned DUTY_MAX  = DEF_DUTY_MAX,
  parameter int unsigned INIT_DUTY = 5,
  parameter int unsigned RAMP_DIV  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              period_start,
  input  logic              cmd_valid,
  input  logic [DUTY_W-1:0] cmd_duty,
  output logic              cmd_ready,
  input  logic              inc_pulse,
  input  logic              dec_pulse,
  output logic [DUTY_W-1:0] duty_out,
  output logic [DUTY_W-1:0] target,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic              busy_q, busy_d;
  logic              cmd_ready_q;
  logic              step_tick_c;

  pwm_period_prescaler #(
    .RAMP_DIV(RAMP_DIV)
  ) u_prescaler (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (state_q == IDLE),
    .period_start_i(period_start),
    .step_tick_c   (step_tick_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      duty_q      <= DUTY_W'(INIT_DUTY);
      target_q    <= DUTY_W'(INIT_DUTY);
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      target_q    <= target_d;
      busy_q      <= busy_d;
      cmd_ready_q <= 1'b1;
    end
  end

  // Target update: command beats inc beats dec.
  always_comb begin
    target_d = target_q;
    if (cmd_valid && cmd_ready_q) begin
      target_d = DUTY_W'(clamp_max(32'(cmd_duty), DUTY_MAX));
    end else if (inc_pulse) begin
      target_d = DUTY_W'(sat_adjust(32'(target_q), 1'b1, DUTY_MAX));
    end else if (dec_pulse) begin
      target_d = DUTY_W'(sat_adjust(32'(target_q), 1'b0, DUTY_MAX));
    end
  end

  // Ramp FSM; the step direction always follows the target held at the step.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: ;
      RAMP: begin
        if (step_tick_c && (duty_q != target_q)) begin
          duty_d = DUTY_W'(sat_adjust(32'(duty_q), target_q > duty_q, DUTY_MAX));
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (duty_d != target_d);
    state_d = busy_d ? RAMP : IDLE;
  end

  assign duty_out  = duty_q;
  assign target    = target_q;
  assign busy      = busy_q;
  assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Self-checking bench for pwm_duty_ramp_ctrl against a cycle-level behavioural model.
module tb_pwm_duty_ramp_ctrl;

  localparam int DUTY_W    = 4;
  localparam int DUTY_MAX  = 10;
  localparam int INIT_DUTY = 5;
  localparam int RAMP_DIV  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              period_start = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [DUTY_W-1:0] cmd_duty = '0;
  logic              cmd_ready;
  logic              inc_pulse = 1'b0;
  logic              dec_pulse = 1'b0;
  logic [DUTY_W-1:0] duty_out;
  logic [DUTY_W-1:0] target;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: applied duty, target, strobes counted toward the next step.
  int m_duty   = INIT_DUTY;
  int m_target = INIT_DUTY;
  int m_pre    = 0;
  int prev_duty = INIT_DUTY;
  bit prev_ps   = 1'b0;

  pwm_duty_ramp_ctrl #(
    .DUTY_W   (DUTY_W),
    .DUTY_MAX (DUTY_MAX),
    .INIT_DUTY(INIT_DUTY),
    .RAMP_DIV (RAMP_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .period_start(period_start),
    .cmd_valid   (cmd_valid),
    .cmd_duty    (cmd_duty),
    .cmd_ready   (cmd_ready),
    .inc_pulse   (inc_pulse),
    .dec_pulse   (dec_pulse),
    .duty_out    (duty_out),
    .target      (target),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, advance the model across the edge, sample 1 time unit later.
  task automatic tick(input bit ps, input bit cv, input int cd, input bit inc,
                      input bit dec, input bit r);
    bit ramping;
    bit step;
    period_start = ps;
    cmd_valid    = cv;
    cmd_duty     = DUTY_W'(cd);
    inc_pulse    = inc;
    dec_pulse    = dec;
    rst          = r;
    @(posedge clk);
    prev_duty = m_duty;
    prev_ps   = ps;
    if (r) begin
      m_duty = INIT_DUTY; m_target = INIT_DUTY; m_pre = 0;
    end else begin
      ramping = (m_duty != m_target);
      step    = ramping && ps && (m_pre == RAMP_DIV - 1);
      if (!ramping)  m_pre = 0;
      else if (ps)   m_pre = (m_pre + 1) % RAMP_DIV;
      if (step)      m_duty = m_duty + ((m_target > m_duty) ? 1 : -1);
      if (cv)        m_target = (cd > DUTY_MAX) ? DUTY_MAX : cd;
      else if (inc)  m_target = (m_target + 1 > DUTY_MAX) ? DUTY_MAX : m_target + 1;
      else if (dec)  m_target = (m_target == 0) ? 0 : m_target - 1;
    end
    cyc++;
    #1;
  endtask

  function automatic bit strobe();
    return (cyc % 10) == 0;
  endfunction

  task automatic test_reset();
    tick(0, 0, 0, 0, 0, 1);
    checks++;
    if ({duty_out, target, busy, cmd_ready} !== {4'd5, 4'd5, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: got duty=%0d target=%0d busy=%b ready=%b, want 5 5 0 1",
               duty_out, target, busy, cmd_ready);
    end
    for (int i = 0; i < 60; i++) begin
      tick(strobe(), 0, 0, 0, 0, 0);
      checks++;
      if ({duty_out, target, busy} !== {4'd5, 4'd5, 1'b0}) begin
        errors++;
        $display("FAIL idle_hold cyc=%0d: got duty=%0d target=%0d busy=%b, want 5 5 0",
                 cyc, duty_out, target, busy);
      end
    end
  endtask

  // Runs n cycles with a strobe every 10 clocks, checking DUT against the model each cycle.
  task automatic run_checked(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick(strobe(), 0, 0, 0, 0, 0);
      checks++;
      if (duty_out !== DUTY_W'(m_duty) || target !== DUTY_W'(m_target) ||
          busy !== (m_duty != m_target) || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s cyc=%0d: got duty=%0d target=%0d busy=%b, want %0d %0d %b",
                 tag, cyc, duty_out, target, busy, m_duty, m_target, m_duty != m_target);
      end
      checks++;
      if (int'(duty_out) != prev_duty &&
          (!prev_ps || int'(duty_out) - prev_duty > 1 || prev_duty - int'(duty_out) > 1)) begin
        errors++;
        $display("FAIL %s_step_rule cyc=%0d: duty %0d -> %0d, strobe=%b",
                 tag, cyc, prev_duty, duty_out, prev_ps);
      end
    end
  endtask

  task automatic test_ramp_up();
    tick(strobe(), 1, 8, 0, 0, 0);
    checks++;
    if ({target, busy, duty_out} !== {4'd8, 1'b1, 4'd5}) begin
      errors++;
      $display("FAIL cmd_accept: got target=%0d busy=%b duty=%0d, want 8 1 5",
               target, busy, duty_out);
    end
    run_checked(160, "ramp_up");
    checks++;
    if ({duty_out, busy} !== {4'd8, 1'b0}) begin
      errors++;
      $display("FAIL ramp_up_end: got duty=%0d busy=%b, want 8 0", duty_out, busy);
    end
  endtask

  task automatic test_clamp();
    tick(strobe(), 1, 15, 0, 0, 0);
    checks++;
    if (target !== 4'd10) begin
      errors++;
      $display("FAIL clamp_target: got %0d, want 10", target);
    end
    run_checked(120, "clamp_ramp");
    tick(strobe(), 0, 0, 1, 0, 0);
    checks++;
    if ({duty_out, target, busy} !== {4'd10, 4'd10, 1'b0}) begin
      errors++;
      $display("FAIL inc_at_max: got duty=%0d target=%0d busy=%b, want 10 10 0",
               duty_out, target, busy);
    end
  endtask

  task automatic test_floor_and_priority();
    tick(strobe(), 1, 0, 0, 0, 0);
    run_checked(420, "ramp_down");
    tick(strobe(), 0, 0, 0, 1, 0);
    checks++;
    if ({duty_out, target, busy} !== {4'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL dec_at_zero: got duty=%0d target=%0d busy=%b, want 0 0 0",
               duty_out, target, busy);
    end
    tick(strobe(), 1, 3, 1, 1, 0);
    checks++;
    if (target !== 4'd3) begin
      errors++;
      $display("FAIL cmd_priority: got target=%0d, want 3", target);
    end
    tick(strobe(), 0, 0, 1, 1, 0);
    checks++;
    if (target !== 4'd4) begin
      errors++;
      $display("FAIL inc_over_dec: got target=%0d, want 4", target);
    end
    run_checked(200, "after_prio");
  endtask

  task automatic test_retarget();
    int guard = 0;
    tick(0, 0, 0, 0, 0, 1);
    tick(strobe(), 1, 9, 0, 0, 0);
    while (m_duty != 7 && guard < 300) begin
      run_checked(1, "to_seven");
      guard++;
    end
    checks++;
    if (guard >= 300) begin
      errors++;
      $display("FAIL reach_seven_timeout: duty=%0d, want 7", duty_out);
    end
    tick(strobe(), 1, 2, 0, 0, 0);
    run_checked(260, "reverse");
    checks++;
    if ({duty_out, target, busy} !== {4'd2, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL reverse_end: got duty=%0d target=%0d busy=%b, want 2 2 0",
               duty_out, target, busy);
    end
  endtask

  task automatic test_reset_midramp();
    int guard = 0;
    tick(strobe(), 1, 10, 0, 0, 0);
    while (m_duty != 8 && guard < 400) begin
      run_checked(1, "to_eight");
      guard++;
    end
    checks++;
    if (guard >= 400) begin
      errors++;
      $display("FAIL reach_eight_timeout: duty=%0d, want 8", duty_out);
    end
    tick(strobe(), 1, 1, 0, 0, 1);
    checks++;
    if ({duty_out, target, busy, cmd_ready} !== {4'd5, 4'd5, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_midramp: got duty=%0d target=%0d busy=%b ready=%b, want 5 5 0 1",
               duty_out, target, busy, cmd_ready);
    end
    tick(strobe(), 1, 6, 0, 0, 0);
    run_checked(60, "post_reset");
    checks++;
    if ({duty_out, busy} !== {4'd6, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_end: got duty=%0d busy=%b, want 6 0", duty_out, busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom % 4) == 0, ($urandom % 20) == 0, int'($urandom % 16),
           ($urandom % 15) == 0, ($urandom % 15) == 0, ($urandom % 700) == 0);
      checks++;
      if (duty_out !== DUTY_W'(m_duty) || target !== DUTY_W'(m_target) ||
          busy !== (m_duty != m_target)) begin
        errors++;
        $display("FAIL random cyc=%0d: got duty=%0d target=%0d busy=%b, want %0d %0d %b",
                 cyc, duty_out, target, busy, m_duty, m_target, m_duty != m_target);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_clamp();
    test_floor_and_priority();
    test_retarget();
    test_reset_midramp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
